dp_pipe: RTL and testbench
==========================

Name: dp_pipe

Overview:
- Parametrised successor to the 16-bit single-cycle datapath.
- Contains a register file with 2**IDX_W registers, an ALU, a barrel shifter and a 4-bit SZCV flag register.
- Adds a registered write-back stage, with optional forwarding, and a registered output port.
- The source mux replaces the tri-state result bus. The controller drives one operation per cycle through ex_en.

Parameters:
WIDTH, 16, datapath and register width (>=8, power of 2)
IDX_W, 3, register index width; register count = 2**IDX_W
IMM_W, 8, immediate width; zero-extended to WIDTH

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
ex_en  input  1  operation valid this cycle
src_sel  input  2  result source: 00 ALU, 01 shifter, 10 immediate, 11 data_in
op3  input  4  ALU/shift operation code
immd  input  IMM_W  immediate; immd[log2(WIDTH)-1:0] is the shift amount
ar_idx  input  IDX_W  bus_A read index
br_idx  input  IDX_W  bus_B read index
wr_idx  input  IDX_W  write-back index
wr_en  input  1  write result to wr_idx
flag_en  input  1  update SZCV (ALU/shifter sources only)
data_in  input  WIDTH  external input value
out_en  input  1  capture bus_B to data_out
data_out  output  WIDTH  registered output value
out_valid  output  1  one-cycle pulse, data_out updated
szcv  output  4  flag register {S,Z,C,V}

Behaviour:
- Reset: rst sampled high at a clk edge clears:
  - all registers, data_out, out_valid, szcv;
  - wb_valid, which drops any pending write.
- Inputs are ignored while rst is high.
- Reads: bus_A and bus_B are combinational from the register file.
  - With forwarding, an index equal to wb_idx while wb_valid is set reads wb_data instead.
- ALU op3 codes, all mod 2**WIDTH:
  - 0000 ADD A+B
  - 0001 SUB A-B
  - 0010 AND
  - 0011 OR
  - 0100 XOR
  - 0101 CMP: result A-B; flags per SUB; wr_en is ignored.
  - 0110 MOV: result B
  - Other codes: result 0, flags unchanged.
- Shifter op3 codes operate on bus_B; amount n = immd mod WIDTH:
  - 1000 SLL
  - 1001 ROL
  - 1010 SRL
  - 1011 SRA
  - Other codes: result B, flags unchanged.
- Flags, registered at the end of the execute cycle when ex_en & flag_en & src_sel[1]==0:
  - S = result MSB.
  - Z = (result==0).
  - ADD: C = carry out.
  - SUB/CMP: C = 1 when A<B unsigned (borrow).
  - ADD/SUB/CMP: V = signed overflow.
  - Logic ops and MOV: C=0, V=0.
  - SLL/SRL/SRA: C = last bit shifted out, 0 when n=0.
  - ROL: C = result LSB when n>0, 0 when n=0.
  - All shifts: V=0.
- Pipeline timing, operation executed in cycle t:
  - Edge ending t: wb_valid<=ex_en&wr_en (0 for CMP), wb_idx<=wr_idx, wb_data<=result.
  - Edge ending t+1: if wb_valid, reg[wb_idx]<=wb_data. The register file reads the new value from cycle t+2.
- Back-to-back writes to the same index: the later write wins.
  - wb_data always holds the newest result, so forwarding returns the newest result.
- Output: when ex_en & out_en, edge ending t sets data_out<=bus_B (forwarding applied) and out_valid<=1.
  - Otherwise out_valid<=0 and data_out holds.
- ex_en=0: no state change except wb_valid<=0 and out_valid<=0. A pending write-back still completes.
- Same-cycle write and output of one index: data_out gets the pre-operation value of bus_B.

Optional Feature:
- Macro DP_PIPE_FWD_EN.
- Defined: both read ports forward wb_data when the read index matches wb_idx and wb_valid is set.
- Undefined: no forwarding. A read in cycle t+1 of a register written by the op in cycle t returns the old value. The controller must insert one idle cycle.

Test Plan:
- Reset then ex_en, src_sel=10, immd=8'h5A, wr_idx=1, wr_en -> reg1=16'h005A from cycle t+2; szcv stays 0000.
- reg1=16'h7FFF, reg2=16'h0001, ADD ar=1 br=2 wr=3 flag_en -> reg3=16'h8000, szcv=1001. Then CMP ar=2 br=2 -> szcv=0100, reg3 unchanged.
- reg4=16'h8001, shifter op3=1011 n=1 br=4 flag_en -> result 16'hC000, C=1, S=1. Then op3=1001 n=4 -> 16'h0018, C=0.
- With DP_PIPE_FWD_EN, back-to-back ops:
  - cycle t: immd 8'h10 -> reg5;
  - cycle t+1: ADD ar=5 br=5 wr=6;
  - expected: reg6=16'h0020.
  - Without the macro, the same sequence gives reg6 = 2*(old reg5).
- out_en with br_idx=1 (reg1=16'h005A) -> data_out=16'h005A with a one-cycle out_valid pulse. Hold out_en low -> out_valid=0, data_out held.
- Write issued in cycle t, rst asserted in cycle t+1 -> pending write dropped; all registers, szcv, data_out = 0.

Source files
------------

// File: rtl/dp_pipe.sv
// dp_pipe: parametrised datapath with a register file, ALU, barrel shifter,
// SZCV flag register, a registered write-back stage and a registered output.
//
// Optional feature macro: DP_PIPE_FWD_EN
//   defined   -> both read ports forward wb_data on an index match with a
//                pending write-back
//   undefined -> no forwarding; a dependent read needs one idle cycle
//
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   ex_en             operation valid this cycle
//   src_sel           result source: 00 ALU, 01 shifter, 10 immediate, 11 data_in
//   op3               ALU / shifter operation code
//   immd              immediate (zero-extended); low bits give the shift amount
//   ar_idx, br_idx    bus_A / bus_B read indices
//   wr_idx, wr_en     write-back index and enable
//   flag_en           update SZCV (ALU / shifter sources only)
//   data_in           external input value
//   out_en            capture bus_B into data_out
//   data_out          registered output value
//   out_valid         one-cycle pulse when data_out is updated
//   szcv              flag register {S,Z,C,V}
module dp_pipe #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned IDX_W = 3,
   parameter int unsigned IMM_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ex_en,
   input  logic [1:0]       src_sel,
   input  logic [3:0]       op3,
   input  logic [IMM_W-1:0] immd,
   input  logic [IDX_W-1:0] ar_idx,
   input  logic [IDX_W-1:0] br_idx,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic             wr_en,
   input  logic             flag_en,
   input  logic [WIDTH-1:0] data_in,
   input  logic             out_en,
   output logic [WIDTH-1:0] data_out,
   output logic             out_valid,
   output logic [3:0]       szcv
);

   localparam int unsigned SH_W = $clog2(WIDTH);
   localparam int unsigned NREG = 1 << IDX_W;

   typedef enum logic [1:0] {
      SRC_ALU = 2'b00,
      SRC_SHF = 2'b01,
      SRC_IMM = 2'b10,
      SRC_IN  = 2'b11
   } src_t;

   typedef enum logic [3:0] {
      OP_ADD = 4'b0000,
      OP_SUB = 4'b0001,
      OP_AND = 4'b0010,
      OP_OR  = 4'b0011,
      OP_XOR = 4'b0100,
      OP_CMP = 4'b0101,
      OP_MOV = 4'b0110,
      OP_SLL = 4'b1000,
      OP_ROL = 4'b1001,
      OP_SRL = 4'b1010,
      OP_SRA = 4'b1011
   } op_t;

   logic [WIDTH-1:0] rf [NREG];
   logic             wb_valid;
   logic [IDX_W-1:0] wb_idx;
   logic [WIDTH-1:0] wb_data;

   logic [WIDTH-1:0] bus_a, bus_b;

`ifdef DP_PIPE_FWD_EN
   always_comb begin
      bus_a = (wb_valid && (ar_idx == wb_idx)) ? wb_data : rf[ar_idx];
      bus_b = (wb_valid && (br_idx == wb_idx)) ? wb_data : rf[br_idx];
   end
`else
   always_comb begin
      bus_a = rf[ar_idx];
      bus_b = rf[br_idx];
   end
`endif

   logic [SH_W-1:0]  sh_n;
   logic [WIDTH:0]   sum_ext, dif_ext, sll_ext, srl_ext, sra_ext;
   logic [WIDTH-1:0] alu_res, shf_res, result;
   logic             alu_c, alu_v, alu_fl, shf_c, shf_fl;
   logic             is_cmp, flag_upd, c_new, v_new;

   always_comb begin
      sh_n    = immd[SH_W-1:0];
      sum_ext = {1'b0, bus_a} + {1'b0, bus_b};
      dif_ext = {1'b0, bus_a} - {1'b0, bus_b};
      // Extra guard bit catches the last bit shifted out; it stays 0 for n=0.
      sll_ext = {1'b0, bus_b} << sh_n;
      srl_ext = {bus_b, 1'b0} >> sh_n;
      sra_ext = $signed({bus_b, 1'b0}) >>> sh_n;

      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      alu_fl  = 1'b1;
      case (op3)
         OP_ADD: begin
            alu_res = sum_ext[WIDTH-1:0];
            alu_c   = sum_ext[WIDTH];
            alu_v   = (bus_a[WIDTH-1] == bus_b[WIDTH-1]) &&
                      (sum_ext[WIDTH-1] != bus_a[WIDTH-1]);
         end
         OP_SUB, OP_CMP: begin
            alu_res = dif_ext[WIDTH-1:0];
            alu_c   = dif_ext[WIDTH];
            alu_v   = (bus_a[WIDTH-1] != bus_b[WIDTH-1]) &&
                      (dif_ext[WIDTH-1] != bus_a[WIDTH-1]);
         end
         OP_AND:  alu_res = bus_a & bus_b;
         OP_OR:   alu_res = bus_a | bus_b;
         OP_XOR:  alu_res = bus_a ^ bus_b;
         OP_MOV:  alu_res = bus_b;
         default: alu_fl  = 1'b0;
      endcase

      shf_res = bus_b;
      shf_c   = 1'b0;
      shf_fl  = 1'b1;
      case (op3)
         OP_SLL: begin
            shf_res = sll_ext[WIDTH-1:0];
            shf_c   = sll_ext[WIDTH];
         end
         OP_ROL: begin
            shf_res = (bus_b << sh_n) | (bus_b >> (WIDTH - sh_n));
            shf_c   = (sh_n != '0) & shf_res[0];
         end
         OP_SRL: begin
            shf_res = srl_ext[WIDTH:1];
            shf_c   = srl_ext[0];
         end
         OP_SRA: begin
            shf_res = sra_ext[WIDTH:1];
            shf_c   = sra_ext[0];
         end
         default: shf_fl = 1'b0;
      endcase

      result   = alu_res;
      c_new    = alu_c;
      v_new    = alu_v;
      flag_upd = 1'b0;
      case (src_sel)
         SRC_ALU: flag_upd = alu_fl;
         SRC_SHF: begin
            result   = shf_res;
            c_new    = shf_c;
            v_new    = 1'b0;
            flag_upd = shf_fl;
         end
         SRC_IMM: result = WIDTH'(immd);
         SRC_IN:  result = data_in;
         default: result = alu_res;
      endcase

      is_cmp = (src_sel == SRC_ALU) && (op3 == OP_CMP);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < NREG; i++) rf[i] <= '0;
         wb_valid  <= 1'b0;
         wb_idx    <= '0;
         wb_data   <= '0;
         data_out  <= '0;
         out_valid <= 1'b0;
         szcv      <= '0;
      end else begin
         if (wb_valid) rf[wb_idx] <= wb_data;
         wb_valid  <= ex_en & wr_en & ~is_cmp;
         out_valid <= ex_en & out_en;
         if (ex_en) begin
            wb_idx  <= wr_idx;
            wb_data <= result;
            if (out_en) data_out <= bus_b;
            if (flag_en && flag_upd)
               szcv <= {result[WIDTH-1], result == '0, c_new, v_new};
         end
      end
   end

endmodule

// File: tb/tb_dp_pipe.sv
// Directed self-checking bench for dp_pipe (default parameters).
// Register contents are observed through out_en reads of bus_B.
module tb_dp_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_en, wr_en, flag_en, out_en;
   logic [1:0]  src_sel;
   logic [3:0]  op3;
   logic [7:0]  immd;
   logic [2:0]  ar_idx, br_idx, wr_idx;
   logic [15:0] data_in;
   logic [15:0] data_out;
   logic        out_valid;
   logic [3:0]  szcv;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   dp_pipe #(.WIDTH(16), .IDX_W(3), .IMM_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .ex_en     (ex_en),
      .src_sel   (src_sel),
      .op3       (op3),
      .immd      (immd),
      .ar_idx    (ar_idx),
      .br_idx    (br_idx),
      .wr_idx    (wr_idx),
      .wr_en     (wr_en),
      .flag_en   (flag_en),
      .data_in   (data_in),
      .out_en    (out_en),
      .data_out  (data_out),
      .out_valid (out_valid),
      .szcv      (szcv)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic clear_ctl();
      ex_en = 1'b0; wr_en = 1'b0; flag_en = 1'b0; out_en = 1'b0;
   endtask

   // Drive one operation for one cycle; returns #1 after the edge ending it.
   task automatic issue(input logic [1:0] src, input logic [3:0] op, input logic [7:0] imm,
                        input logic [2:0] a, input logic [2:0] b, input logic [2:0] w,
                        input logic we, input logic fe, input logic oe);
      ex_en = 1'b1; src_sel = src; op3 = op; immd = imm;
      ar_idx = a; br_idx = b; wr_idx = w; wr_en = we; flag_en = fe; out_en = oe;
      @(posedge clk);
      #1;
      clear_ctl();
   endtask

   task automatic idle(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic read_reg(input string tag, input logic [2:0] idx, input logic [15:0] exp);
      issue(2'b00, 4'b0111, 8'h00, 3'd0, idx, 3'd0, 1'b0, 1'b0, 1'b1);
      check(tag, data_out, exp);
      check({tag, "_vld"}, out_valid, 1'b1);
   endtask

   initial begin
      rst = 1'b1;
      clear_ctl();
      src_sel = '0; op3 = '0; immd = '0;
      ar_idx = '0; br_idx = '0; wr_idx = '0; data_in = '0;
      idle(2);
      rst = 1'b0;
      check("rst_szcv", szcv, 4'b0000);
      check("rst_dout", data_out, 16'h0000);
      check("rst_oval", out_valid, 1'b0);

      // Immediate write; flag_en has no effect on the immediate source
      issue(2'b10, 4'b0000, 8'h5A, 3'd0, 3'd0, 3'd1, 1'b1, 1'b1, 1'b0);
      check("imm_szcv", szcv, 4'b0000);
      idle(1);
      read_reg("r1_5a", 3'd1, 16'h005A);
      idle(1);
      check("idle_oval", out_valid, 1'b0);
      check("idle_dout", data_out, 16'h005A);

      // ex_en low: enables are ignored
      src_sel = 2'b10; immd = 8'hEE; wr_idx = 3'd1; wr_en = 1'b1;
      br_idx = 3'd2; out_en = 1'b1; flag_en = 1'b1;
      idle(1);
      clear_ctl();
      check("noex_oval", out_valid, 1'b0);
      check("noex_dout", data_out, 16'h005A);
      idle(1);
      read_reg("noex_r1", 3'd1, 16'h005A);

      // data_in source
      data_in = 16'hABCD;
      issue(2'b11, 4'b0000, 8'h00, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0);
      idle(1);
      read_reg("din_r0", 3'd0, 16'hABCD);

      // Build r1=7FFF, r2=0001 via shift and subtract
      issue(2'b10, 4'b0000, 8'h80, 3'd0, 3'd0, 3'd7, 1'b1, 1'b0, 1'b0);
      issue(2'b10, 4'b0000, 8'h01, 3'd0, 3'd0, 3'd2, 1'b1, 1'b0, 1'b0);
      idle(1);
      issue(2'b01, 4'b1000, 8'h08, 3'd0, 3'd7, 3'd7, 1'b1, 1'b0, 1'b0);
      idle(1);
      issue(2'b00, 4'b0001, 8'h00, 3'd7, 3'd2, 3'd1, 1'b1, 1'b1, 1'b0);
      check("sub_ovf_szcv", szcv, 4'b0001);
      idle(1);
      issue(2'b00, 4'b0000, 8'h00, 3'd1, 3'd2, 3'd3, 1'b1, 1'b1, 1'b0);
      check("add_szcv", szcv, 4'b1001);
      idle(1);
      read_reg("add_r3", 3'd3, 16'h8000);
      issue(2'b00, 4'b0101, 8'h00, 3'd2, 3'd2, 3'd3, 1'b1, 1'b1, 1'b0);
      check("cmp_szcv", szcv, 4'b0100);
      idle(1);
      read_reg("cmp_r3", 3'd3, 16'h8000);
      issue(2'b00, 4'b0001, 8'h00, 3'd2, 3'd3, 3'd4, 1'b1, 1'b1, 1'b0);
      check("sub_brw_szcv", szcv, 4'b1011);
      idle(1);
      read_reg("sub_r4", 3'd4, 16'h8001);

      // Shifter on r4=8001
      issue(2'b01, 4'b1011, 8'h01, 3'd0, 3'd4, 3'd5, 1'b1, 1'b1, 1'b0);
      check("sra_szcv", szcv, 4'b1010);
      idle(1);
      read_reg("sra_r5", 3'd5, 16'hC000);
      issue(2'b01, 4'b1001, 8'h04, 3'd0, 3'd4, 3'd5, 1'b1, 1'b1, 1'b0);
      check("rol_szcv", szcv, 4'b0000);
      idle(1);
      read_reg("rol_r5", 3'd5, 16'h0018);
      issue(2'b01, 4'b1000, 8'h00, 3'd0, 3'd4, 3'd0, 1'b0, 1'b1, 1'b0);
      check("sll0_szcv", szcv, 4'b1000);
      issue(2'b01, 4'b1010, 8'h11, 3'd0, 3'd4, 3'd0, 1'b0, 1'b1, 1'b0);
      check("srl_szcv", szcv, 4'b0010);
      issue(2'b00, 4'b0111, 8'h00, 3'd4, 3'd4, 3'd6, 1'b1, 1'b1, 1'b0);
      check("aluoth_szcv", szcv, 4'b0010);
      idle(1);
      read_reg("aluoth_r6", 3'd6, 16'h0000);
      issue(2'b00, 4'b0100, 8'h00, 3'd4, 3'd4, 3'd0, 1'b0, 1'b1, 1'b0);
      check("xor_szcv", szcv, 4'b0100);
      issue(2'b01, 4'b0000, 8'h03, 3'd0, 3'd4, 3'd6, 1'b1, 1'b1, 1'b0);
      check("shfoth_szcv", szcv, 4'b0100);
      idle(1);
      read_reg("shfoth_r6", 3'd6, 16'h8001);

      // Back-to-back dependent ops (r5 currently 0018)
      issue(2'b10, 4'b0000, 8'h10, 3'd0, 3'd0, 3'd5, 1'b1, 1'b0, 1'b0);
      issue(2'b00, 4'b0000, 8'h00, 3'd5, 3'd5, 3'd6, 1'b1, 1'b0, 1'b0);
      idle(1);
`ifdef DP_PIPE_FWD_EN
      read_reg("b2b_r6", 3'd6, 16'h0020);
`else
      read_reg("b2b_r6", 3'd6, 16'h0030);
`endif
      read_reg("b2b_r5", 3'd5, 16'h0010);

      // Same-cycle write and output of r1 (7FFF): output sees the old value
      issue(2'b10, 4'b0000, 8'h33, 3'd0, 3'd1, 3'd1, 1'b1, 1'b0, 1'b1);
      check("samecyc_dout", data_out, 16'h7FFF);
      check("samecyc_oval", out_valid, 1'b1);
      idle(1);
      read_reg("samecyc_r1", 3'd1, 16'h0033);

      // Back-to-back writes to one index: later wins
      issue(2'b10, 4'b0000, 8'h11, 3'd0, 3'd0, 3'd7, 1'b1, 1'b0, 1'b0);
      issue(2'b10, 4'b0000, 8'h22, 3'd0, 3'd0, 3'd7, 1'b1, 1'b0, 1'b0);
      idle(1);
      read_reg("ww_r7", 3'd7, 16'h0022);
      issue(2'b10, 4'b0000, 8'h44, 3'd0, 3'd0, 3'd7, 1'b1, 1'b0, 1'b0);
`ifdef DP_PIPE_FWD_EN
      read_reg("fwd_r7", 3'd7, 16'h0044);
`else
      read_reg("fwd_r7", 3'd7, 16'h0022);
`endif
      idle(1);
      read_reg("late_r7", 3'd7, 16'h0044);

      // Reset in the cycle after a write drops the pending write
      issue(2'b10, 4'b0000, 8'h77, 3'd0, 3'd0, 3'd2, 1'b1, 1'b0, 1'b0);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      check("rst2_szcv", szcv, 4'b0000);
      check("rst2_dout", data_out, 16'h0000);
      check("rst2_oval", out_valid, 1'b0);
      idle(1);
      read_reg("rst2_r2", 3'd2, 16'h0000);
      read_reg("rst2_r1", 3'd1, 16'h0000);
      read_reg("rst2_r4", 3'd4, 16'h0000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
